// File: rtl/swd_xfer_ctrl.sv
// swd_xfer_ctrl
//   Sequences one debug-port transfer at a time. It takes a command, hands it
//   to the SWD engine, retries on WAIT answers with an idle gap between tries,
//   and reports the final outcome on a ready/valid response channel.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_retry_max, cfg_gap     WAIT retry limit and idle gap, read when used
//   abort                      level, cancels pending retries
//   cmd_*                      command channel (valid/ready)
//   rsp_*                      response channel (valid/ready)
//   swd_go / swd_done / swd_*  engine link: go is held until done falls
module swd_xfer_ctrl #(
  parameter int RETRY_W = 8,
  parameter int GAP_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RETRY_W-1:0] cfg_retry_max,
  input  logic [GAP_W-1:0]   cfg_gap,
  input  logic               abort,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_addr32,
  input  logic               cmd_rnw,
  input  logic               cmd_apndp,
  input  logic [31:0]        cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_ack,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [RETRY_W-1:0] rsp_retries,
  output logic               rsp_aborted,
  output logic               swd_go,
  input  logic               swd_done,
  input  logic [2:0]         swd_ack,
  input  logic [31:0]        swd_dout,
  input  logic               swd_err,
  output logic [1:0]         swd_addr32,
  output logic               swd_rnw,
  output logic               swd_apndp,
  output logic [31:0]        swd_din
);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, EVAL, GAP, RESP} state_t;

  localparam logic [2:0] ACK_OK   = 3'b100;
  localparam logic [2:0] ACK_WAIT = 3'b010;
  localparam logic [RETRY_W-1:0] RETRY_SAT = {RETRY_W{1'b1}};

  state_t             state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               swd_go_q, swd_go_d;
  logic [2:0]         rsp_ack_q, rsp_ack_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic [RETRY_W-1:0] rsp_retries_q, rsp_retries_d;
  logic               rsp_aborted_q, rsp_aborted_d;
  logic [1:0]         swd_addr32_q, swd_addr32_d;
  logic               swd_rnw_q, swd_rnw_d;
  logic               swd_apndp_q, swd_apndp_d;
  logic [31:0]        swd_din_q, swd_din_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic ack_ok, ack_wait;

  // FAULT and malformed acks both take the plain "report" path, so only OK
  // and WAIT need their own decode.
  assign ack_ok   = (swd_ack == ACK_OK);
  assign ack_wait = (swd_ack == ACK_WAIT);

  always_comb begin
    state_d       = state_q;
    rsp_ack_d     = rsp_ack_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_retries_d = rsp_retries_q;
    rsp_aborted_d = rsp_aborted_q;
    swd_addr32_d  = swd_addr32_q;
    swd_rnw_d     = swd_rnw_q;
    swd_apndp_d   = swd_apndp_q;
    swd_din_d     = swd_din_q;
    retry_cnt_d   = retry_cnt_q;
    gap_cnt_d     = gap_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          swd_addr32_d = cmd_addr32;
          swd_rnw_d    = cmd_rnw;
          swd_apndp_d  = cmd_apndp;
          swd_din_d    = cmd_wdata;
          retry_cnt_d  = '0;
          state_d      = ISSUE;
        end
      end
      // done may still be high from the previous transfer because of the
      // engine's go synchroniser; only its fall means the engine has started.
      ISSUE: begin
        if (!swd_done) state_d = BUSY;
      end
      BUSY: begin
        if (swd_done) state_d = EVAL;
      end
      EVAL: begin
        if (ack_wait && !abort && (retry_cnt_q < cfg_retry_max)) begin
          retry_cnt_d = (retry_cnt_q == RETRY_SAT) ? RETRY_SAT : retry_cnt_q + RETRY_W'(1);
          gap_cnt_d   = cfg_gap;
          // A zero gap goes straight back to ISSUE without visiting GAP.
          state_d     = (cfg_gap == '0) ? ISSUE : GAP;
        end else begin
          rsp_ack_d     = swd_ack;
          rsp_retries_d = retry_cnt_q;
          rsp_rdata_d   = swd_rnw_q ? swd_dout : 32'h0;
          rsp_err_d     = ack_ok ? swd_err : 1'b1;
          rsp_aborted_d = ack_wait && abort;
          state_d       = RESP;
        end
      end
      // GAP is only ever entered after a WAIT, so an abort here reports WAIT.
      GAP: begin
        if (abort) begin
          rsp_ack_d     = ACK_WAIT;
          rsp_retries_d = retry_cnt_q;
          rsp_rdata_d   = 32'h0;
          rsp_err_d     = 1'b1;
          rsp_aborted_d = 1'b1;
          state_d       = RESP;
        end else begin
          gap_cnt_d = (gap_cnt_q != '0) ? gap_cnt_q - GAP_W'(1) : '0;
          if (gap_cnt_q <= GAP_W'(1)) state_d = ISSUE;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they are glitch
  // free, low during reset, and cmd_ready rises one edge after reset release.
  assign cmd_ready_d = (state_d == IDLE);
  assign rsp_valid_d = (state_d == RESP);
  assign swd_go_d    = (state_d == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      swd_go_q      <= 1'b0;
      rsp_ack_q     <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_retries_q <= '0;
      rsp_aborted_q <= 1'b0;
      swd_addr32_q  <= '0;
      swd_rnw_q     <= 1'b0;
      swd_apndp_q   <= 1'b0;
      swd_din_q     <= '0;
      retry_cnt_q   <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      swd_go_q      <= swd_go_d;
      rsp_ack_q     <= rsp_ack_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_retries_q <= rsp_retries_d;
      rsp_aborted_q <= rsp_aborted_d;
      swd_addr32_q  <= swd_addr32_d;
      swd_rnw_q     <= swd_rnw_d;
      swd_apndp_q   <= swd_apndp_d;
      swd_din_q     <= swd_din_d;
      retry_cnt_q   <= retry_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign swd_go      = swd_go_q;
  assign rsp_ack     = rsp_ack_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_retries = rsp_retries_q;
  assign rsp_aborted = rsp_aborted_q;
  assign swd_addr32  = swd_addr32_q;
  assign swd_rnw     = swd_rnw_q;
  assign swd_apndp   = swd_apndp_q;
  assign swd_din     = swd_din_q;

endmodule

// File: tb/tb_swd_xfer_ctrl.sv
// tb_swd_xfer_ctrl
//   Self-checking bench for swd_xfer_ctrl: a behavioural SWD engine answers
//   go pulses from a per-command list of acks, a table of directed vectors
//   and a randomized batch are compared against an outcome model, and a few
//   hand-written sequences cover abort in GAP and reset at various points.
module tb_swd_xfer_ctrl;

  localparam logic [2:0] OK    = 3'b100;
  localparam logic [2:0] WAITA = 3'b010;
  localparam logic [2:0] FLT   = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_retry_max;
  logic [7:0]  cfg_gap;
  logic        abort;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_addr32;
  logic        cmd_rnw;
  logic        cmd_apndp;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  rsp_retries;
  logic        rsp_aborted;
  logic        swd_go;
  logic        swd_done;
  logic [2:0]  swd_ack;
  logic [31:0] swd_dout;
  logic        swd_err;
  logic [1:0]  swd_addr32;
  logic        swd_rnw;
  logic        swd_apndp;
  logic [31:0] swd_din;

  swd_xfer_ctrl #(.RETRY_W(8), .GAP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_retry_max(cfg_retry_max), .cfg_gap(cfg_gap), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr32(cmd_addr32),
    .cmd_rnw(cmd_rnw), .cmd_apndp(cmd_apndp), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ack(rsp_ack),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_retries(rsp_retries),
    .rsp_aborted(rsp_aborted),
    .swd_go(swd_go), .swd_done(swd_done), .swd_ack(swd_ack), .swd_dout(swd_dout),
    .swd_err(swd_err), .swd_addr32(swd_addr32), .swd_rnw(swd_rnw),
    .swd_apndp(swd_apndp), .swd_din(swd_din)
  );

  always #5 clk = ~clk;

  // Engine model: idles with done high; on go it drops done two edges later,
  // works for a random extra 0..3 cycles, then raises done with the ack for
  // this attempt (attempt index counted from eng_base, last entry repeats).
  logic [3:0][2:0] eng_acks;
  logic [31:0]     eng_dout;
  logic            eng_err;
  int              eng_base;
  int              eng_starts = 0;
  int              eng_cnt;
  int              eng_lat;
  logic            eng_active;
  logic [1:0]      eng_ix;

  always_comb eng_ix = ((eng_starts - eng_base) > 3) ? 2'd3 : 2'(eng_starts - eng_base);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swd_done   <= 1'b1;
      swd_ack    <= 3'b000;
      swd_dout   <= 32'h0;
      swd_err    <= 1'b0;
      eng_active <= 1'b0;
      eng_cnt    <= 0;
      eng_lat    <= 0;
    end else if (!eng_active) begin
      if (swd_go && swd_done) begin
        eng_active <= 1'b1;
        eng_cnt    <= 0;
        eng_lat    <= int'($urandom_range(0, 3));
      end
    end else begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 1) swd_done <= 1'b0;
      if (eng_cnt == 2 + eng_lat) begin
        swd_done   <= 1'b1;
        swd_ack    <= eng_acks[eng_ix];
        swd_dout   <= eng_dout;
        swd_err    <= eng_err;
        eng_active <= 1'b0;
        eng_starts <= eng_starts + 1;
      end
    end
  end

  typedef struct {
    logic            rnw;
    logic [1:0]      addr;
    logic            apndp;
    logic [31:0]     wdata;
    logic [7:0]      rmax;
    logic [7:0]      gap;
    logic            abort_lvl;
    logic [3:0][2:0] acks;
    logic [31:0]     dout;
    logic            derr;
    int              bp;
    logic [2:0]      e_ack;
    logic            e_err;
    logic [7:0]      e_ret;
    logic [31:0]     e_rdata;
    logic            e_abt;
    int              e_pulses;
  } vec_t;

  int total_checks = 0;
  int bad_checks   = 0;

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic rnw, input logic [1:0] addr, input logic apndp,
                               input logic [31:0] wdata, input logic [7:0] rmax, input logic [7:0] gap,
                               input logic abort_lvl, input logic [3:0][2:0] acks,
                               input logic [31:0] dout, input logic derr, input int bp,
                               input logic [2:0] e_ack, input logic e_err, input logic [7:0] e_ret,
                               input logic [31:0] e_rdata, input logic e_abt, input int e_pulses);
    vec_t v;
    v.rnw = rnw; v.addr = addr; v.apndp = apndp; v.wdata = wdata;
    v.rmax = rmax; v.gap = gap; v.abort_lvl = abort_lvl; v.acks = acks;
    v.dout = dout; v.derr = derr; v.bp = bp;
    v.e_ack = e_ack; v.e_err = e_err; v.e_ret = e_ret; v.e_rdata = e_rdata;
    v.e_abt = e_abt; v.e_pulses = e_pulses;
    return v;
  endfunction

  // Outcome model: walk the attempts; a WAIT is retried while retries remain
  // and abort is low, anything else (or an aborted WAIT) ends the command.
  function automatic vec_t model(input vec_t v);
    vec_t       r;
    int         n;
    logic [2:0] a;
    logic [1:0] ix;
    r = v;
    n = 0;
    a = v.acks[0];
    for (int k = 0; k < 16; k++) begin
      ix = (n > 3) ? 2'd3 : 2'(n);
      a  = v.acks[ix];
      if (a == WAITA && !v.abort_lvl && n < int'(v.rmax)) n++;
      else break;
    end
    r.e_ack    = a;
    r.e_err    = (a == OK) ? v.derr : 1'b1;
    r.e_ret    = 8'(n);
    r.e_rdata  = v.rnw ? v.dout : 32'h0;
    r.e_abt    = (a == WAITA) && v.abort_lvl;
    r.e_pulses = n + 1;
    return r;
  endfunction

  // Present a command and wait for its acceptance; returns 0 on timeout.
  task automatic sendCmd(input vec_t v, output bit ok);
    int n;
    cfg_retry_max = v.rmax;
    cfg_gap       = v.gap;
    abort         = v.abort_lvl;
    eng_acks      = v.acks;
    eng_dout      = v.dout;
    eng_err       = v.derr;
    eng_base      = eng_starts;
    cmd_addr32    = v.addr;
    cmd_rnw       = v.rnw;
    cmd_apndp     = v.apndp;
    cmd_wdata     = v.wdata;
    cmd_valid     = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    if (!ok) checkOutput("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input string nm);
    bit   ok;
    int   pulses, low_run, min_low, n;
    logic prev;
    logic [63:0] exp_pack;
    sendCmd(v, ok);
    if (!ok) return;
    pulses = 0; low_run = 0; min_low = 1000; prev = 1'b0; n = 0;
    while (n < 2000) begin
      if (swd_go && !prev) begin
        if (pulses > 0 && low_run < min_low) min_low = low_run;
        pulses++;
      end
      if (!swd_go) low_run++;
      else low_run = 0;
      prev = swd_go;
      if (rsp_valid) break;
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checkOutput({nm, "_rsp_timeout"}, 64'(rsp_valid), 64'd1);
      return;
    end
    checkOutput({nm, "_ack"},     64'(rsp_ack),     64'(v.e_ack));
    checkOutput({nm, "_err"},     64'(rsp_err),     64'(v.e_err));
    checkOutput({nm, "_retries"}, 64'(rsp_retries), 64'(v.e_ret));
    checkOutput({nm, "_rdata"},   64'(rsp_rdata),   64'(v.e_rdata));
    checkOutput({nm, "_aborted"}, 64'(rsp_aborted), 64'(v.e_abt));
    checkOutput({nm, "_pulses"},  64'(pulses),      64'(v.e_pulses));
    checkOutput({nm, "_swd_fields"}, {29'h0, swd_addr32, swd_rnw, swd_apndp, swd_din},
                {29'h0, v.addr, v.rnw, v.apndp, v.wdata});
    if (pulses > 1)
      checkOutput({nm, "_gap_short"}, 64'(min_low >= int'(v.gap)), 64'd1);
    exp_pack = {19'h0, v.e_ack, v.e_err, v.e_ret, v.e_abt, v.e_rdata};
    for (int i = 0; i < v.bp; i++) begin
      @(negedge clk);
      checkOutput({nm, "_bp_hold"}, {19'h0, rsp_ack, rsp_err, rsp_retries, rsp_aborted, rsp_rdata},
                  exp_pack);
      checkOutput({nm, "_bp_valid_ready"}, {62'h0, rsp_valid, cmd_ready}, 64'b10);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({nm, "_rsp_done"}, {62'h0, rsp_valid, cmd_ready}, 64'b01);
    abort = 1'b0;
  endtask

  // Abort raised while the controller sits in its first inter-retry gap.
  task automatic abortInGap();
    vec_t v;
    bit   ok;
    int   pulses, cnt, n;
    logic prev;
    bit   armed;
    v = mkv(1'b0, 2'd1, 1'b1, 32'h1111_2222, 8'd3, 8'd20, 1'b0,
            {WAITA, WAITA, WAITA, WAITA}, 32'h0, 1'b0, 0,
            WAITA, 1'b1, 8'd1, 32'h0, 1'b1, 1);
    sendCmd(v, ok);
    if (!ok) return;
    pulses = 0; cnt = 0; n = 0; prev = 1'b0; armed = 1'b0;
    while (n < 500) begin
      if (swd_go && !prev) pulses++;
      prev = swd_go;
      if (!armed && pulses == 1 && !swd_go && swd_done) armed = 1'b1;
      if (armed && cnt < 4) begin
        cnt++;
        if (cnt == 4) abort = 1'b1;
      end
      if (rsp_valid) break;
      @(negedge clk);
      n++;
    end
    checkOutput("gap_abort_valid",   64'(rsp_valid),   64'd1);
    checkOutput("gap_abort_aborted", 64'(rsp_aborted), 64'd1);
    checkOutput("gap_abort_ack",     64'(rsp_ack),     64'(WAITA));
    checkOutput("gap_abort_err",     64'(rsp_err),     64'd1);
    checkOutput("gap_abort_retries", 64'(rsp_retries), 64'd1);
    checkOutput("gap_abort_pulses",  64'(pulses),      64'd1);
    abort = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("gap_abort_done", {62'h0, rsp_valid, cmd_ready}, 64'b01);
  endtask

  // Reset asserted mid-command: mode 0 in ISSUE (go high), 1 in BUSY (just
  // after go fell), 2 while a response is waiting for rsp_ready.
  task automatic resetDuring(input int mode, input string nm);
    vec_t v;
    bit   ok, hit;
    int   n;
    logic prev;
    v = mkv(1'b1, 2'd3, 1'b1, 32'hFFFF_0001, 8'd0, 8'd0, 1'b0,
            {OK, OK, OK, OK}, 32'h5555_AAAA, 1'b0, 0,
            OK, 1'b0, 8'd0, 32'h5555_AAAA, 1'b0, 1);
    sendCmd(v, ok);
    if (!ok) return;
    n = 0; prev = 1'b0; hit = 1'b0;
    while (n < 200 && !hit) begin
      case (mode)
        0:       hit = swd_go;
        1:       hit = prev && !swd_go;
        default: hit = rsp_valid;
      endcase
      prev = swd_go;
      if (!hit) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput({nm, "_reached"}, 64'(hit), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput({nm, "_async"}, {57'h0, swd_go, cmd_ready, rsp_valid, rsp_ack, rsp_err},
                64'h0);
    checkOutput({nm, "_fields"}, {26'h0, swd_addr32, swd_rnw, swd_apndp, swd_din, rsp_retries},
                64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput({nm, "_ready_before_edge"}, 64'(cmd_ready), 64'd0);
    @(negedge clk);
    checkOutput({nm, "_ready_after_edge"}, 64'(cmd_ready), 64'd1);
  endtask

  vec_t table_v[11];

  initial begin
    rst_n = 1'b0;
    cfg_retry_max = 8'd0; cfg_gap = 8'd0; abort = 1'b0;
    cmd_valid = 1'b0; cmd_addr32 = 2'd0; cmd_rnw = 1'b0; cmd_apndp = 1'b0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    eng_acks = '0; eng_dout = 32'h0; eng_err = 1'b0; eng_base = 0;

    //              rnw   addr  apndp  wdata          rmax   gap    abt
    table_v[0]  = mkv(1'b1, 2'd2, 1'b1, 32'h0000_0000, 8'd3, 8'd2, 1'b0,
                      {OK, OK, OK, OK}, 32'h1234_5678, 1'b0, 2,
                      OK, 1'b0, 8'd0, 32'h1234_5678, 1'b0, 1);
    table_v[1]  = mkv(1'b0, 2'd1, 1'b0, 32'hCAFE_F00D, 8'd3, 8'd4, 1'b0,
                      {OK, OK, WAITA, WAITA}, 32'hDEAD_BEEF, 1'b0, 0,
                      OK, 1'b0, 8'd2, 32'h0, 1'b0, 3);
    table_v[2]  = mkv(1'b1, 2'd0, 1'b0, 32'h0, 8'd2, 8'd1, 1'b0,
                      {WAITA, WAITA, WAITA, WAITA}, 32'hA5A5_A5A5, 1'b0, 1,
                      WAITA, 1'b1, 8'd2, 32'hA5A5_A5A5, 1'b0, 3);
    table_v[3]  = mkv(1'b0, 2'd3, 1'b1, 32'h0BB0_0BB0, 8'd3, 8'd2, 1'b0,
                      {FLT, FLT, FLT, FLT}, 32'h1357_9BDF, 1'b0, 10,
                      FLT, 1'b1, 8'd0, 32'h0, 1'b0, 1);
    table_v[4]  = mkv(1'b1, 2'd2, 1'b0, 32'h0, 8'd3, 8'd2, 1'b0,
                      {3'b111, 3'b111, 3'b111, 3'b111}, 32'h0BAD_F00D, 1'b0, 0,
                      3'b111, 1'b1, 8'd0, 32'h0BAD_F00D, 1'b0, 1);
    table_v[5]  = mkv(1'b0, 2'd0, 1'b1, 32'h0, 8'd0, 8'd3, 1'b0,
                      {OK, OK, OK, WAITA}, 32'h0, 1'b0, 0,
                      WAITA, 1'b1, 8'd0, 32'h0, 1'b0, 1);
    table_v[6]  = mkv(1'b1, 2'd1, 1'b1, 32'h0, 8'd1, 8'd0, 1'b0,
                      {OK, OK, OK, OK}, 32'h0000_0001, 1'b1, 0,
                      OK, 1'b1, 8'd0, 32'h0000_0001, 1'b0, 1);
    table_v[7]  = mkv(1'b0, 2'd2, 1'b0, 32'h8000_0001, 8'd1, 8'd0, 1'b0,
                      {OK, OK, OK, WAITA}, 32'h0, 1'b0, 0,
                      OK, 1'b0, 8'd1, 32'h0, 1'b0, 2);
    table_v[8]  = mkv(1'b0, 2'd3, 1'b0, 32'h0, 8'd3, 8'd2, 1'b1,
                      {WAITA, WAITA, WAITA, WAITA}, 32'h0, 1'b0, 0,
                      WAITA, 1'b1, 8'd0, 32'h0, 1'b1, 1);
    table_v[9]  = mkv(1'b1, 2'd0, 1'b0, 32'h0, 8'd3, 8'd2, 1'b1,
                      {OK, OK, OK, OK}, 32'h0000_0077, 1'b0, 0,
                      OK, 1'b0, 8'd0, 32'h0000_0077, 1'b0, 1);
    table_v[10] = mkv(1'b1, 2'd1, 1'b1, 32'h0, 8'd3, 8'd3, 1'b0,
                      {FLT, FLT, FLT, WAITA}, 32'h2468_ACE0, 1'b0, 1,
                      FLT, 1'b1, 8'd1, 32'h2468_ACE0, 1'b0, 2);

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {57'h0, swd_go, cmd_ready, rsp_valid, rsp_ack, rsp_err}, 64'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_first_edge", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    checkOutput("ready_after_first_edge", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 11; i++) applyStimulus(table_v[i], $sformatf("vec%0d", i));

    abortInGap();

    for (int i = 0; i < 40; i++) begin
      vec_t r;
      int   k;
      r.rnw = 1'(($urandom));
      r.addr = 2'($urandom);
      r.apndp = 1'($urandom);
      r.wdata = $urandom;
      r.rmax = 8'($urandom_range(0, 3));
      r.gap = 8'($urandom_range(0, 5));
      r.abort_lvl = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < 4; j++) begin
        k = int'($urandom_range(0, 9));
        if (k < 5)       r.acks[j] = WAITA;
        else if (k < 8)  r.acks[j] = OK;
        else if (k == 8) r.acks[j] = FLT;
        else             r.acks[j] = 3'($urandom);
      end
      r.dout = $urandom;
      r.derr = 1'($urandom);
      r.bp = int'($urandom_range(0, 3));
      r = model(r);
      applyStimulus(r, $sformatf("rnd%0d", i));
    end

    resetDuring(0, "rst_issue");
    resetDuring(1, "rst_busy");
    resetDuring(2, "rst_resp");

    applyStimulus(table_v[0], "after_reset");

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
